// File: rtl/exu_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues operations and consumes results; the slave is the unit.
interface exu_muldiv_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TAG_W     = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [DATAWIDTH-1:0] in_src1;
  logic [DATAWIDTH-1:0] in_src2;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/exu_muldiv.sv
// RV32M execute unit: shift-add multiply and restoring divide, one bit per cycle,
// operating on magnitudes with sign correction applied on the final iteration.
module exu_muldiv #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TAG_W     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  output logic           busy,
  exu_muldiv_if.slave    bus
);
  localparam int unsigned W    = DATAWIDTH;
  localparam int unsigned CntW = $clog2(DATAWIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [W-1:0]     a_q, hi_q, lo_q;
  logic [CntW-1:0]  cnt_q;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             s1_neg, s2_neg, acc_neg, acc_div0;
  logic [W-1:0]     mag1, mag2;
  logic [W:0]       add_sum, shl;
  logic             ge;
  logic [W-1:0]     hi_n, lo_n;
  logic [2*W-1:0]   prod_s;
  logic [W-1:0]     quo_s, rem_s, result;

  assign bus.in_ready  = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

  // Accept-time operand preparation: signedness, magnitudes and the final sign flag.
  always_comb begin
    s1_neg   = bus.in_src1[W-1] & ((bus.in_op == 3'b001) | (bus.in_op == 3'b010) |
                                   (bus.in_op == 3'b100) | (bus.in_op == 3'b110));
    s2_neg   = bus.in_src2[W-1] & ((bus.in_op == 3'b001) | (bus.in_op == 3'b100) |
                                   (bus.in_op == 3'b110));
    mag1     = s1_neg ? -bus.in_src1 : bus.in_src1;
    mag2     = s2_neg ? -bus.in_src2 : bus.in_src2;
    acc_neg  = (bus.in_op == 3'b110) ? s1_neg : (s1_neg ^ s2_neg);
    acc_div0 = bus.in_op[2] & (bus.in_src2 == '0);
  end

  // One iteration. Multiply: {hi,lo} holds partial product over the multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, a_q};
    shl     = {hi_q, lo_q[W-1]};
    ge      = (shl >= {1'b0, a_q});
    if (!op_q[2]) begin
      if (lo_q[0]) {hi_n, lo_n} = {add_sum, lo_q[W-1:1]};
      else         {hi_n, lo_n} = {1'b0, hi_q, lo_q[W-1:1]};
    end else begin
      hi_n = ge ? shl[W-1:0] - a_q : shl[W-1:0];
      lo_n = {lo_q[W-2:0], ge};
    end
    prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = neg_q ? -hi_n : hi_n;
    case (op_q)
      3'b000:                 result = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*W-1:W];
      3'b100, 3'b101:         result = quo_s;
      default:                result = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      neg_q       <= 1'b0;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q      <= bus.in_op;
            out_tag_q <= bus.in_tag;
            neg_q     <= acc_neg;
            hi_q      <= '0;
            cnt_q     <= CntW'(DATAWIDTH - 1);
            if (acc_div0) begin
              out_data_q  <= bus.in_op[1] ? bus.in_src1 : '1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              a_q     <= bus.in_op[2] ? mag2 : mag1;
              lo_q    <= bus.in_op[2] ? mag1 : mag2;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            out_data_q  <= result;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_muldiv.sv
// Randomised and directed bench for exu_muldiv against a 64-bit arithmetic reference.
module tb_exu_muldiv;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  exu_muldiv_if #(.DATAWIDTH(DW), .TAG_W(TW)) bus ();

  exu_muldiv #(.DATAWIDTH(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_src1  = $urandom;
    bus.in_src2  = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int stall);
    int          lat;
    logic [31:0] exp;
    int          exp_lat;
    exp     = model(op, a, b);
    exp_lat = (op[2] && b == 0) ? 1 : DW + 1;
    check_eq("accept_ready", bus.in_ready, 1);
    start_op(op, a, b, tag);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("data", bus.out_data, exp);
    check_eq("tag", bus.out_tag, tag);
    check_eq("busy_done", busy, 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_data", bus.out_data, exp);
      check_eq("hold_tag", bus.out_tag, tag);
      check_eq("hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("post_valid", bus.out_valid, 0);
    check_eq("post_ready", bus.in_ready, 1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_tag", bus.out_tag, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready", bus.in_ready, 1);
    check_eq("rst_busy", busy, 0);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd1, 5'd5, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    do_op(3'd5, 32'd100, 32'd7, 5'd8, 0);
    do_op(3'd7, 32'd100, 32'd7, 5'd9, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    do_op(3'd4, 32'd5, 32'd0, 5'h1A, 0);
    do_op(3'd7, 32'd5, 32'd0, 5'h1A, 2);
    do_op(3'd0, 32'd0, 32'h1234_5678, 5'd12, 0);
    // Ten-cycle backpressure, then a new op issued right after the handshake.
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 10);
    do_op(3'd2, 32'h8765_4321, 32'h0000_0003, 5'd14, 0);

    // Flush during the tenth CALC cycle.
    start_op(3'd0, 32'd9, 32'd9, 5'd15);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_calc_ready", bus.in_ready, 1);
    check_eq("flush_calc_valid", bus.out_valid, 0);
    expect_quiet("flush_calc_quiet", 40);
    do_op(3'd5, 32'd1000, 32'd33, 5'd16, 0);

    // Flush together with in_valid while idle.
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_src1  = 32'd3;
    bus.in_src2  = 32'd3;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check_eq("flush_idle_busy", busy, 0);
    expect_quiet("flush_idle_quiet", 40);

    // Flush while a result is pending, with out_ready high.
    start_op(3'd4, 32'd5, 32'd0, 5'd17);
    check_eq("pend_valid", bus.out_valid, 1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("flush_done_valid", bus.out_valid, 0);
    check_eq("flush_done_ready", bus.in_ready, 1);

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), $urandom_range(0, 3));
    end

    // Reset mid-CALC with the clock stopped.
    do_op(3'd5, 32'd77, 32'd5, 5'd21, 0);
    start_op(3'd0, 32'd11, 32'd13, 5'd22);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", bus.out_valid, 0);
    check_eq("midrst_data", bus.out_data, 0);
    check_eq("midrst_tag", bus.out_tag, 0);
    check_eq("midrst_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check_eq("postrst_ready", bus.in_ready, 1);
    expect_quiet("postrst_quiet", 40);
    do_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd23, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
